// File: rtl/me_search_ctrl_if.sv
// rtl/me_search_ctrl_if.sv - handshake, candidate and result bus of the motion-estimation search controller
interface me_search_ctrl_if #(
    parameter int RANGE = 8,
    parameter int SAD_W = 16,
    parameter int MV_W  = $clog2(2 * RANGE) + 1
);
    logic                    start;
    logic                    abort;
    logic                    busy;
    logic                    done;
    logic                    cb_load;
    logic [3:0]              cb_row;
    logic                    cand_valid;
    logic signed [MV_W-1:0]  cand_x;
    logic signed [MV_W-1:0]  cand_y;
    logic                    roll;
    logic                    row_load;
    logic [SAD_W-1:0]        sad16_in;
    logic [4*SAD_W-1:0]      sad8_in;
    logic [SAD_W-1:0]        best_sad16;
    logic signed [MV_W-1:0]  best_mv16_x;
    logic signed [MV_W-1:0]  best_mv16_y;
    logic [4*SAD_W-1:0]      best_sad8;
    logic [4*MV_W-1:0]       best_mv8_x;
    logic [4*MV_W-1:0]       best_mv8_y;

    modport master (
        input  start, abort, sad16_in, sad8_in,
        output busy, done, cb_load, cb_row, cand_valid, cand_x, cand_y, roll, row_load,
               best_sad16, best_mv16_x, best_mv16_y, best_sad8, best_mv8_x, best_mv8_y
    );

    modport slave (
        output start, abort, sad16_in, sad8_in,
        input  busy, done, cb_load, cb_row, cand_valid, cand_x, cand_y, roll, row_load,
               best_sad16, best_mv16_x, best_mv16_y, best_sad8, best_mv8_x, best_mv8_y
    );
endinterface

// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - full-search motion-estimation controller with 16x16 and 8x8 minimum-SAD trackers
module me_search_ctrl #(
    parameter int RANGE    = 8,
    parameter int LOAD_CYC = 16,
    parameter int PIPE_LAT = 2,
    parameter int SAD_W    = 16,
    parameter int MV_W     = $clog2(2 * RANGE) + 1
) (
    input  logic              clk,
    input  logic              rst,
    me_search_ctrl_if.master  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, DONE} state_t;

    localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-RANGE);
    localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(RANGE - 1);
    localparam int DW = $clog2(PIPE_LAT + 1);

    state_t state, state_n;

    logic                   cb_load_q, cand_valid_q, roll_q, row_load_q, done_q;
    logic [3:0]             cb_row_q;
    logic signed [MV_W-1:0] cand_x_q, cand_y_q, nx, ny;
    logic [DW-1:0]          dcnt;

    logic                   dv [PIPE_LAT];
    logic signed [MV_W-1:0] dx [PIPE_LAT];
    logic signed [MV_W-1:0] dy [PIPE_LAT];

    // Trackers 0..3 are the 8x8 sub-blocks, tracker 4 is the whole 16x16 block
    logic [SAD_W-1:0]       insad [5];
    logic [SAD_W-1:0]       tsad  [5];
    logic [SAD_W-1:0]       nsad  [5];
    logic signed [MV_W-1:0] tmx [5], tmy [5], nmx [5], nmy [5];

    logic [SAD_W-1:0]       best_sad16_q;
    logic signed [MV_W-1:0] best_mv16_x_q, best_mv16_y_q;
    logic [4*SAD_W-1:0]     best_sad8_q;
    logic [4*MV_W-1:0]      best_mv8_x_q, best_mv8_y_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = LOAD;
            LOAD:    if (cb_row_q == 4'(LOAD_CYC - 1)) state_n = SCAN;
            SCAN:    if (cand_x_q == MV_MAX && cand_y_q == MV_MAX) state_n = DRAIN;
            DRAIN:   if (dcnt == DW'(PIPE_LAT - 1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (bus.abort && (state == LOAD || state == SCAN || state == DRAIN))
            state_n = IDLE;
    end

    always_comb begin
        nx = MV_MIN;
        ny = MV_MIN;
        if (state == SCAN) begin
            if (cand_x_q == MV_MAX) begin
                nx = MV_MIN;
                ny = cand_y_q + MV_W'(1);
            end else begin
                nx = cand_x_q + MV_W'(1);
                ny = cand_y_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cb_load_q    <= 1'b0;
            cb_row_q     <= 4'd0;
            cand_valid_q <= 1'b0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            roll_q       <= 1'b0;
            row_load_q   <= 1'b0;
            done_q       <= 1'b0;
            dcnt         <= '0;
        end else begin
            state        <= state_n;
            cb_load_q    <= (state_n == LOAD);
            cb_row_q     <= (state_n == LOAD && state == LOAD) ? cb_row_q + 4'd1 : 4'd0;
            cand_valid_q <= (state_n == SCAN);
            cand_x_q     <= (state_n == SCAN) ? nx : '0;
            cand_y_q     <= (state_n == SCAN) ? ny : '0;
            roll_q       <= (state_n == SCAN) && (nx != MV_MIN);
            row_load_q   <= (state_n == SCAN) && (nx == MV_MIN);
            done_q       <= (state_n == DONE);
            dcnt         <= (state == DRAIN) ? dcnt + DW'(1) : '0;
        end
    end

    // Candidate coordinates ride alongside the array latency; abort flushes them
    always_ff @(posedge clk) begin
        if (rst || state_n == IDLE) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dv[i] <= 1'b0;
                dx[i] <= '0;
                dy[i] <= '0;
            end
        end else begin
            dv[0] <= cand_valid_q;
            dx[0] <= cand_x_q;
            dy[0] <= cand_y_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dv[i] <= dv[i-1];
                dx[i] <= dx[i-1];
                dy[i] <= dy[i-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++)
            insad[k] = bus.sad8_in[k*SAD_W +: SAD_W];
        insad[4] = bus.sad16_in;
    end

    // Strict less-than keeps the earliest raster candidate on ties
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            nsad[k] = tsad[k];
            nmx[k]  = tmx[k];
            nmy[k]  = tmy[k];
            if (dv[PIPE_LAT-1] && insad[k] < tsad[k]) begin
                nsad[k] = insad[k];
                nmx[k]  = dx[PIPE_LAT-1];
                nmy[k]  = dy[PIPE_LAT-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 5; k++) begin
                tsad[k] <= '0;
                tmx[k]  <= '0;
                tmy[k]  <= '0;
            end
        end else if (state == IDLE && state_n == LOAD) begin
            for (int k = 0; k < 5; k++) begin
                tsad[k] <= '1;
                tmx[k]  <= '0;
                tmy[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 5; k++) begin
                tsad[k] <= nsad[k];
                tmx[k]  <= nmx[k];
                tmy[k]  <= nmy[k];
            end
        end
    end

    // Results are captured with the final compare folded in, so they are valid with done
    always_ff @(posedge clk) begin
        if (rst) begin
            best_sad16_q  <= '0;
            best_mv16_x_q <= '0;
            best_mv16_y_q <= '0;
            best_sad8_q   <= '0;
            best_mv8_x_q  <= '0;
            best_mv8_y_q  <= '0;
        end else if (state == DRAIN && state_n == DONE) begin
            best_sad16_q  <= nsad[4];
            best_mv16_x_q <= nmx[4];
            best_mv16_y_q <= nmy[4];
            for (int k = 0; k < 4; k++) begin
                best_sad8_q[k*SAD_W +: SAD_W] <= nsad[k];
                best_mv8_x_q[k*MV_W +: MV_W]  <= nmx[k];
                best_mv8_y_q[k*MV_W +: MV_W]  <= nmy[k];
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.cb_load     = cb_load_q;
    assign bus.cb_row      = cb_row_q;
    assign bus.cand_valid  = cand_valid_q;
    assign bus.cand_x      = cand_x_q;
    assign bus.cand_y      = cand_y_q;
    assign bus.roll        = roll_q;
    assign bus.row_load    = row_load_q;
    assign bus.best_sad16  = best_sad16_q;
    assign bus.best_mv16_x = best_mv16_x_q;
    assign bus.best_mv16_y = best_mv16_y_q;
    assign bus.best_sad8   = best_sad8_q;
    assign bus.best_mv8_x  = best_mv8_x_q;
    assign bus.best_mv8_y  = best_mv8_y_q;
endmodule

// File: tb/tb_me_search_ctrl.sv
// tb/tb_me_search_ctrl.sv - self-checking bench for me_search_ctrl with SAD-array model and result scoreboard
module tb_me_search_ctrl;
    localparam int MV_W = 5;

    logic clk;
    logic rst;
    me_search_ctrl_if bus ();

    me_search_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int s16;
        int x16;
        int y16;
        int s8 [4];
        int x8 [4];
        int y8 [4];
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cur_mode = 0;
    bit   mon_en = 0;
    exp_t vec [4];
    exp_t sb [$];
    exp_t last;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference SAD surfaces; k=0..3 selects an 8x8 sub-block, k=4 the 16x16 block
    function automatic int sad_of(input int mode, input int k, input int x, input int y);
        int v;
        case (mode)
            0: begin
                v = iabs(x - 3) + iabs(y + 2);
                return (k == 4) ? v : v + 10 * k;
            end
            1: return 100;
            2: begin
                if (k == 4) return iabs(x + 5) + iabs(y - 6) + 1;
                case (k)
                    0: return (x == 0  && y == 0)  ? 5 : 200;
                    1: return (x == 7  && y == -8) ? 6 : 200;
                    2: return (x == -8 && y == 7)  ? 7 : 200;
                    default: return (x == 1 && y == 1) ? 8 : 200;
                endcase
            end
            default: begin
                v = 1000 - ((y + 8) * 16 + (x + 8));
                return (k == 4) ? v : v + k;
            end
        endcase
    endfunction

    // Two-stage array model; invalid slots drive 0 so a DUT that ignores valid picks it up
    logic   p1_v, p2_v;
    int     p1_x, p1_y, p2_x, p2_y;
    always @(posedge clk) begin
        if (rst) begin
            p1_v <= 1'b0; p2_v <= 1'b0;
            p1_x <= 0; p1_y <= 0; p2_x <= 0; p2_y <= 0;
        end else begin
            p1_v <= bus.cand_valid;
            p1_x <= int'($signed(bus.cand_x));
            p1_y <= int'($signed(bus.cand_y));
            p2_v <= p1_v; p2_x <= p1_x; p2_y <= p1_y;
        end
    end

    always_comb begin
        bus.sad16_in = '0;
        bus.sad8_in  = '0;
        if (p2_v) begin
            bus.sad16_in = 16'(sad_of(cur_mode, 4, p2_x, p2_y));
            for (int k = 0; k < 4; k++)
                bus.sad8_in[k*16 +: 16] = 16'(sad_of(cur_mode, k, p2_x, p2_y));
        end
    end

    // Cycle monitor: raster order, row wrap, output exclusivity, result stability
    int   ex, ey, nval, er;
    logic prev_valid, prev_cb;
    logic [129:0] best_now, prev_best;
    assign best_now = {bus.best_sad16, bus.best_mv16_x, bus.best_mv16_y,
                       bus.best_sad8, bus.best_mv8_x, bus.best_mv8_y};

    always @(negedge clk) begin
        if (mon_en) begin
            chk("excl_load_scan", longint'(bus.cb_load & bus.cand_valid), 0);
            chk("excl_roll_rowload", longint'(bus.roll & bus.row_load), 0);
            chk("shift_iff_valid", longint'(bus.roll | bus.row_load), longint'(bus.cand_valid));
            if (bus.cand_valid) begin
                if (!prev_valid) begin
                    ex = -8; ey = -8; nval = 0;
                end
                chk("cand_x", longint'($signed(bus.cand_x)), ex);
                chk("cand_y", longint'($signed(bus.cand_y)), ey);
                chk("row_load", longint'(bus.row_load), (ex == -8) ? 1 : 0);
                nval++;
                if (ex == 7) begin ex = -8; ey++; end else ex++;
            end
            if (bus.cb_load) begin
                if (!prev_cb) er = 0;
                chk("cb_row", longint'(bus.cb_row), er);
                er++;
            end
            if (!bus.done && best_now != prev_best)
                chk("best_changed_without_done", 1, 0);
        end
        prev_valid = bus.cand_valid;
        prev_cb    = bus.cb_load;
        prev_best  = best_now;
    end

    task automatic check_results(input exp_t e);
        chk("best_sad16", longint'(bus.best_sad16), e.s16);
        chk("best_mv16_x", longint'($signed(bus.best_mv16_x)), e.x16);
        chk("best_mv16_y", longint'($signed(bus.best_mv16_y)), e.y16);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("best_sad8[%0d]", k), longint'(bus.best_sad8[k*16 +: 16]), e.s8[k]);
            chk($sformatf("best_mv8_x[%0d]", k),
                longint'($signed(bus.best_mv8_x[k*MV_W +: MV_W])), e.x8[k]);
            chk($sformatf("best_mv8_y[%0d]", k),
                longint'($signed(bus.best_mv8_y[k*MV_W +: MV_W])), e.y8[k]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, longint'(bus.busy), 0);
        chk({tag, "_done"}, longint'(bus.done), 0);
        chk({tag, "_cb_load"}, longint'(bus.cb_load), 0);
        chk({tag, "_cb_row"}, longint'(bus.cb_row), 0);
        chk({tag, "_cand_valid"}, longint'(bus.cand_valid), 0);
        chk({tag, "_cand_x"}, longint'(bus.cand_x), 0);
        chk({tag, "_cand_y"}, longint'(bus.cand_y), 0);
        chk({tag, "_roll"}, longint'(bus.roll), 0);
        chk({tag, "_row_load"}, longint'(bus.row_load), 0);
        chk({tag, "_best"}, longint'(best_now != '0), 0);
    endtask

    // Start one full search; done is expected 274 cycles after the first post-start cycle
    task automatic run_search(input int idx, input int glitch_at);
        int   k;
        exp_t e;
        cur_mode = vec[idx].mode;
        sb.push_back(vec[idx]);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        chk("busy_after_start", longint'(bus.busy), 1);
        k = 0;
        while (k < 400 && !bus.done) begin
            bus.start = (k == glitch_at);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("done_cycle", k, 274);
            chk("busy_in_done", longint'(bus.busy), 1);
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                check_results(e);
                last = e;
            end
        end
        chk("cand_count", nval, 256);
        @(negedge clk);
        chk("done_one_pulse", longint'(bus.done), 0);
        chk("idle_after_done", longint'(bus.busy), 0);
    endtask

    task automatic run_abort(input int idx);
        int nd;
        cur_mode = vec[idx].mode;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (115) @(negedge clk);
        chk("scan_before_abort", longint'(bus.cand_valid), 1);
        bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        chk("busy_after_abort", longint'(bus.busy), 0);
        chk("valid_after_abort", longint'(bus.cand_valid), 0);
        nd = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("no_done_after_abort", nd, 0);
        check_results(last);
    endtask

    initial begin
        vec[0].mode = 0; vec[0].s16 = 0;   vec[0].x16 = 3;  vec[0].y16 = -2;
        vec[0].s8 = '{0, 10, 20, 30};      vec[0].x8 = '{3, 3, 3, 3};     vec[0].y8 = '{-2, -2, -2, -2};
        vec[1].mode = 1; vec[1].s16 = 100; vec[1].x16 = -8; vec[1].y16 = -8;
        vec[1].s8 = '{100, 100, 100, 100}; vec[1].x8 = '{-8, -8, -8, -8}; vec[1].y8 = '{-8, -8, -8, -8};
        vec[2].mode = 2; vec[2].s16 = 1;   vec[2].x16 = -5; vec[2].y16 = 6;
        vec[2].s8 = '{5, 6, 7, 8};         vec[2].x8 = '{0, 7, -8, 1};    vec[2].y8 = '{0, -8, 7, 1};
        vec[3].mode = 3; vec[3].s16 = 745; vec[3].x16 = 7;  vec[3].y16 = 7;
        vec[3].s8 = '{745, 746, 747, 748}; vec[3].x8 = '{7, 7, 7, 7};     vec[3].y8 = '{7, 7, 7, 7};
        last.mode = 0; last.s16 = 0; last.x16 = 0; last.y16 = 0;
        last.s8 = '{0, 0, 0, 0}; last.x8 = '{0, 0, 0, 0}; last.y8 = '{0, 0, 0, 0};

        rst = 1'b1; bus.start = 1'b1; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        bus.start = 1'b0; rst = 1'b0;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_in_idle", longint'(bus.busy), 0);
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++)
            run_search(i, (i == 0) ? 50 : -1);

        run_abort(3);
        run_search(3, -1);

        cur_mode = 0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (150) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid_scan");
        rst = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        run_search(0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
